tl_error_slave: RTL and testbench
=================================

TL_ERROR_SLAVE -- requirements
Module: tl_error_slave

Interface
REQ-001 SHALL have parameter MAX_SIZE, default 6, the largest legal log2 transfer size in bytes; beat is 8 bytes.
REQ-002 SHALL have port clock  in  1  the single clock.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port auto_in_a_ready  out  1  A-channel accept.
REQ-005 SHALL have port auto_in_a_valid  in  1  A-channel beat valid.
REQ-006 SHALL have port auto_in_a_bits_opcode  in  3  0=PutFull, 1=PutPartial, 2=Arith, 3=Logical, 4=Get, 5=Hint.
REQ-007 SHALL have port auto_in_a_bits_size  in  4  log2 bytes.
REQ-008 SHALL have port auto_in_a_bits_source  in  5  requester ID.
REQ-009 SHALL have port auto_in_d_ready  in  1  D-channel accept.
REQ-010 SHALL have port auto_in_d_valid  out  1  D-channel beat valid.
REQ-011 SHALL have D outputs auto_in_d_bits_opcode (3), _param (2), _size (4), _source (5), _sink (1), _denied (1), _data (64), _corrupt (1).

Function
REQ-012 SHALL be the TL error device that consumes the output side of the upstream buffer: every request is answered with denied=1, param=0, sink=0, data=0.
REQ-013 SHALL use FSM states IDLE, DRAIN, RESP; one request in flight at a time.
REQ-014 SHALL drive a_ready=1 in IDLE and DRAIN, a_ready=0 in RESP.
REQ-015 SHALL compute beats = 1 if size<=3, else 2^(size-3); size>MAX_SIZE SHALL be treated as MAX_SIZE.
REQ-016 SHALL treat opcodes 0,1,2,3 as data-carrying A (beats per REQ-015) and opcodes 4,5 as single A beat.
REQ-017 SHALL, on the first A fire in IDLE, capture opcode, size, source; if it is the last A beat go RESP, else go DRAIN with A beat counter = beats-1.
REQ-018 SHALL, in DRAIN, decrement the A counter per fire and go RESP on the fire that reaches zero; opcode/size/source of non-first beats are ignored.
REQ-019 SHALL assert d_valid the cycle after the last A fire (latency 1) and hold it with stable bits until d_ready.
REQ-020 SHALL respond: Put -> opcode 0 AccessAck, 1 beat; Get/Arith/Logical -> opcode 1 AccessAckData, beats per REQ-015; Hint -> opcode 2 HintAck, 1 beat; d_size and d_source echo the captured values.
REQ-021 SHALL, in RESP, count D fires and return to IDLE on the last fire; a_ready rises the cycle after.
REQ-022 SHALL treat opcodes 6,7 as Get-class (AccessAckData) for robustness.
REQ-023 SHALL never assert d_valid in IDLE or DRAIN.

Reset
REQ-024 SHALL on reset assertion, at any time including mid-burst, immediately force state IDLE, counters 0, d_valid=0, a_ready=1 once reset deasserts; captured fields SHALL reset to 0.
REQ-025 SHALL hold a_ready=0 while reset is asserted.

Configuration
REQ-026 SHALL support macro TL_ERROR_CORRUPT_EN: defined -> d_corrupt=1 on every AccessAckData beat; undefined -> d_corrupt=0 always; AccessAck/HintAck always corrupt=0.

Structure
REQ-027 SHALL place TL opcode constants (A and D), beat-bytes constant and FSM state enum in shared package tl_pkg.
REQ-028 SHALL instantiate one sub-module tl_beat_counter (load, decrement, last flag), used once for A and once for D.

Verification
REQ-029 SHALL cover Get size=6 source=5 -> one A fire, d_valid next cycle, 8 beats opcode 1 size 6 source 5 denied=1 data=0.
REQ-030 SHALL cover PutFull size=5 source=3 -> 4 A fires, a_ready drops after 4th, single D opcode 0 size 5 source 3.
REQ-031 SHALL cover d_ready held low 5 cycles in RESP -> d_valid stays 1, bits stable, no beat lost, a_ready=0 throughout.
REQ-032 SHALL cover Hint size=2 -> single D opcode 2, corrupt=0; back-to-back Get size=3 accepted the cycle after D fire.
REQ-033 SHALL cover reset asserted during beat 3 of 8-beat response -> d_valid=0 asynchronously, after release next Get answered correctly.
REQ-034 SHALL cover Get size=3 with and without TL_ERROR_CORRUPT_EN -> d_corrupt=1 resp. 0.

Source files
------------

// File: rtl/tl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tl_pkg
//  Description : Shared TileLink opcodes, beat geometry and error-slave FSM
//                states, plus helpers for beat counting and response mapping.
//  Revision    : 1.0  initial release
// ============================================================================
package tl_pkg;

    localparam logic [2:0] TL_A_PUT_FULL    = 3'd0;
    localparam logic [2:0] TL_A_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] TL_A_ARITH       = 3'd2;
    localparam logic [2:0] TL_A_LOGICAL     = 3'd3;
    localparam logic [2:0] TL_A_GET         = 3'd4;
    localparam logic [2:0] TL_A_HINT        = 3'd5;

    localparam logic [2:0] TL_D_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] TL_D_ACCESS_ACK_DATA = 3'd1;
    localparam logic [2:0] TL_D_HINT_ACK        = 3'd2;

    localparam int unsigned TL_BEAT_BYTES = 8;
    localparam int unsigned TL_BEAT_LOG2  = $clog2(TL_BEAT_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_RESP  = 2'd2
    } tl_state_e;

    // Oversized requests are clamped to the largest legal transfer.
    function automatic int unsigned tl_num_beats(input logic [3:0] size,
                                                 input int unsigned max_size);
        int unsigned eff;
        eff = 32'(size);
        if (eff > max_size) eff = max_size;
        if (eff <= TL_BEAT_LOG2) return 32'd1;
        return 32'd1 << (eff - TL_BEAT_LOG2);
    endfunction

    function automatic logic tl_a_has_data(input logic [2:0] op);
        case (op)
            TL_A_PUT_FULL, TL_A_PUT_PARTIAL, TL_A_ARITH, TL_A_LOGICAL: return 1'b1;
            default:                                                  return 1'b0;
        endcase
    endfunction

    // Unknown opcodes 6/7 are answered like a Get.
    function automatic logic [2:0] tl_d_opcode(input logic [2:0] op);
        case (op)
            TL_A_PUT_FULL, TL_A_PUT_PARTIAL:     return TL_D_ACCESS_ACK;
            TL_A_ARITH, TL_A_LOGICAL, TL_A_GET:  return TL_D_ACCESS_ACK_DATA;
            TL_A_HINT:                           return TL_D_HINT_ACK;
            default:                             return TL_D_ACCESS_ACK_DATA;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/tl_beat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tl_beat_counter
//  Description : Remaining-beat counter with load, decrement and a flag that
//                marks the final beat (one beat left).
//  Revision    : 1.0  initial release
// ============================================================================
module tl_beat_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_last
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_load) begin
            count_d = i_load_val;
        end else if (i_dec) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_last = (count_q == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/tl_error_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tl_error_slave
//  Description : TileLink error device; drains each A request and answers it
//                with a denied response. Macro TL_ERROR_CORRUPT_EN flags
//                AccessAckData beats as corrupt.
//  Revision    : 1.0  initial release
// ============================================================================
module tl_error_slave #(
    parameter int MAX_SIZE = 6
) (
    input  logic        clock,
    input  logic        reset,
    output logic        auto_in_a_ready,
    input  logic        auto_in_a_valid,
    input  logic [2:0]  auto_in_a_bits_opcode,
    input  logic [3:0]  auto_in_a_bits_size,
    input  logic [4:0]  auto_in_a_bits_source,
    input  logic        auto_in_d_ready,
    output logic        auto_in_d_valid,
    output logic [2:0]  auto_in_d_bits_opcode,
    output logic [1:0]  auto_in_d_bits_param,
    output logic [3:0]  auto_in_d_bits_size,
    output logic [4:0]  auto_in_d_bits_source,
    output logic        auto_in_d_bits_sink,
    output logic        auto_in_d_bits_denied,
    output logic [63:0] auto_in_d_bits_data,
    output logic        auto_in_d_bits_corrupt
);
    import tl_pkg::*;

    // Wide enough to hold the full beat count of the largest transfer.
    localparam int          CNT_W      = (MAX_SIZE > 3) ? (MAX_SIZE - 2) : 1;
    localparam int unsigned MAX_SIZE_U = MAX_SIZE;

    tl_state_e   state_q, state_d;
    logic [2:0]  opcode_q, opcode_d;
    logic [3:0]  size_q, size_d;
    logic [4:0]  source_q, source_d;

    logic        a_fire, d_fire;
    logic        a_load, a_dec, a_last;
    logic        d_load, d_dec, d_last;
    logic [31:0] a_beats_in;
    logic [31:0] d_beats_next;
    logic [2:0]  d_opcode_next;
    logic [CNT_W-1:0] a_load_val, d_load_val;

    assign auto_in_a_ready = !reset && (state_q != ST_RESP);
    assign auto_in_d_valid = (state_q == ST_RESP);
    assign a_fire          = auto_in_a_ready && auto_in_a_valid;
    assign d_fire          = auto_in_d_valid && auto_in_d_ready;

    assign a_beats_in = tl_a_has_data(auto_in_a_bits_opcode)
                      ? tl_num_beats(auto_in_a_bits_size, MAX_SIZE_U) : 32'd1;
    assign a_load_val = CNT_W'(a_beats_in - 32'd1);

    // Response length follows the captured request, including one still being captured.
    assign d_opcode_next = tl_d_opcode(opcode_d);
    assign d_beats_next  = (d_opcode_next == TL_D_ACCESS_ACK_DATA)
                         ? tl_num_beats(size_d, MAX_SIZE_U) : 32'd1;
    assign d_load_val    = CNT_W'(d_beats_next);

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        size_d   = size_q;
        source_d = source_q;
        a_load   = 1'b0;
        a_dec    = 1'b0;
        d_load   = 1'b0;
        d_dec    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (a_fire) begin
                    opcode_d = auto_in_a_bits_opcode;
                    size_d   = auto_in_a_bits_size;
                    source_d = auto_in_a_bits_source;
                    if (a_beats_in == 32'd1) begin
                        state_d = ST_RESP;
                        d_load  = 1'b1;
                    end else begin
                        state_d = ST_DRAIN;
                        a_load  = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (a_fire) begin
                    a_dec = 1'b1;
                    if (a_last) begin
                        state_d = ST_RESP;
                        d_load  = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                if (d_fire) begin
                    d_dec = 1'b1;
                    if (d_last) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            opcode_q <= '0;
            size_q   <= '0;
            source_q <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            size_q   <= size_d;
            source_q <= source_d;
        end
    end

    tl_beat_counter #(.WIDTH(CNT_W)) u_a_cnt (
        .clk        (clock),
        .rst        (reset),
        .i_load     (a_load),
        .i_load_val (a_load_val),
        .i_dec      (a_dec),
        .o_last     (a_last)
    );

    tl_beat_counter #(.WIDTH(CNT_W)) u_d_cnt (
        .clk        (clock),
        .rst        (reset),
        .i_load     (d_load),
        .i_load_val (d_load_val),
        .i_dec      (d_dec),
        .o_last     (d_last)
    );

    assign auto_in_d_bits_opcode = tl_d_opcode(opcode_q);
    assign auto_in_d_bits_param  = 2'b00;
    assign auto_in_d_bits_size   = size_q;
    assign auto_in_d_bits_source = source_q;
    assign auto_in_d_bits_sink   = 1'b0;
    assign auto_in_d_bits_denied = 1'b1;
    assign auto_in_d_bits_data   = 64'd0;

`ifdef TL_ERROR_CORRUPT_EN
    assign auto_in_d_bits_corrupt = (auto_in_d_bits_opcode == TL_D_ACCESS_ACK_DATA);
`else
    assign auto_in_d_bits_corrupt = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tl_error_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tl_error_slave
//  Description : Randomized self-checking bench for tl_error_slave against a
//                transaction-level model of the error device.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tl_error_slave;

    localparam int MAX_SIZE = 6;
`ifdef TL_ERROR_CORRUPT_EN
    localparam bit CORRUPT_EN = 1'b1;
`else
    localparam bit CORRUPT_EN = 1'b0;
`endif

    logic        clock, reset;
    logic        a_ready, a_valid;
    logic [2:0]  a_opcode;
    logic [3:0]  a_size;
    logic [4:0]  a_source;
    logic        d_ready, d_valid;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [3:0]  d_size;
    logic [4:0]  d_source;
    logic        d_sink, d_denied, d_corrupt;
    logic [63:0] d_data;

    int n_checks = 0;
    int n_fail   = 0;

    tl_error_slave #(.MAX_SIZE(MAX_SIZE)) dut (
        .clock                  (clock),
        .reset                  (reset),
        .auto_in_a_ready        (a_ready),
        .auto_in_a_valid        (a_valid),
        .auto_in_a_bits_opcode  (a_opcode),
        .auto_in_a_bits_size    (a_size),
        .auto_in_a_bits_source  (a_source),
        .auto_in_d_ready        (d_ready),
        .auto_in_d_valid        (d_valid),
        .auto_in_d_bits_opcode  (d_opcode),
        .auto_in_d_bits_param   (d_param),
        .auto_in_d_bits_size    (d_size),
        .auto_in_d_bits_source  (d_source),
        .auto_in_d_bits_sink    (d_sink),
        .auto_in_d_bits_denied  (d_denied),
        .auto_in_d_bits_data    (d_data),
        .auto_in_d_bits_corrupt (d_corrupt)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Beats for a transfer: 8-byte beats, sizes above MAX_SIZE clamp down.
    function automatic int model_beats(input int sz);
        int eff;
        eff = (sz > MAX_SIZE) ? MAX_SIZE : sz;
        return (eff <= 3) ? 1 : 2 ** (eff - 3);
    endfunction

    // Called just after a falling edge; returns just after a falling edge.
    task automatic run_txn(input logic [2:0] op, input logic [3:0] sz, input logic [4:0] src,
                           input int a_gap, input int d_gap, input int d_hold);
        int         nb, a_beats, d_beats, sent, got, cyc;
        logic [2:0] exp_op;
        logic       exp_corr, fire;
        nb       = model_beats(int'(sz));
        a_beats  = (op <= 3'd3) ? nb : 1;
        exp_op   = (op == 3'd0 || op == 3'd1) ? 3'd0 : (op == 3'd5) ? 3'd2 : 3'd1;
        d_beats  = (exp_op == 3'd1) ? nb : 1;
        exp_corr = CORRUPT_EN && (exp_op == 3'd1);

        sent = 0;
        cyc  = 0;
        while (sent < a_beats && cyc < 2000) begin
            check_eq("a_ready_open", 64'(a_ready), 64'(1));
            check_eq("d_valid_quiet", 64'(d_valid), 64'(0));
            a_valid = ($urandom_range(99) >= a_gap);
            if (sent == 0 && a_valid) begin
                a_opcode = op;
                a_size   = sz;
                a_source = src;
            end else begin
                a_opcode = 3'($urandom);
                a_size   = 4'($urandom);
                a_source = 5'($urandom);
            end
            fire = a_valid && a_ready;
            @(posedge clock);
            if (fire) sent++;
            @(negedge clock);
            cyc++;
        end
        a_valid = 1'b0;
        if (sent < a_beats) check_eq("a_phase_timeout", 64'(sent), 64'(a_beats));
        check_eq("d_valid_latency", 64'(d_valid), 64'(1));
        check_eq("a_ready_closed", 64'(a_ready), 64'(0));

        got = 0;
        cyc = 0;
        while (got < d_beats && cyc < 2000) begin
            check_eq("d_valid_hold", 64'(d_valid), 64'(1));
            check_eq("a_ready_resp", 64'(a_ready), 64'(0));
            check_eq("d_opcode", 64'(d_opcode), 64'(exp_op));
            check_eq("d_size", 64'(d_size), 64'(sz));
            check_eq("d_source", 64'(d_source), 64'(src));
            check_eq("d_param_sink", 64'({d_param, d_sink}), 64'(0));
            check_eq("d_denied", 64'(d_denied), 64'(1));
            check_eq("d_data", d_data, 64'(0));
            check_eq("d_corrupt", 64'(d_corrupt), 64'(exp_corr));
            d_ready = (cyc >= d_hold) && ($urandom_range(99) >= d_gap);
            fire    = d_valid && d_ready;
            @(posedge clock);
            if (fire) got++;
            @(negedge clock);
            cyc++;
        end
        d_ready = 1'b0;
        if (got < d_beats) check_eq("d_phase_timeout", 64'(got), 64'(d_beats));
        check_eq("d_valid_done", 64'(d_valid), 64'(0));
        check_eq("a_ready_reopen", 64'(a_ready), 64'(1));
    endtask

    initial begin
        reset    = 1'b1;
        a_valid  = 1'b0;
        a_opcode = '0;
        a_size   = '0;
        a_source = '0;
        d_ready  = 1'b0;
        repeat (3) @(negedge clock);
        check_eq("rst_a_ready", 64'(a_ready), 64'(0));
        check_eq("rst_d_valid", 64'(d_valid), 64'(0));
        reset = 1'b0;
        #1;
        check_eq("post_rst_a_ready", 64'(a_ready), 64'(1));
        check_eq("post_rst_d_valid", 64'(d_valid), 64'(0));

        // Directed scenarios: full-rate Get, multi-beat Put, stalled D, Hint then back-to-back Get.
        run_txn(3'd4, 4'd6, 5'd5, 0, 0, 0);
        run_txn(3'd0, 4'd5, 5'd3, 0, 0, 0);
        run_txn(3'd4, 4'd4, 5'd17, 0, 0, 5);
        run_txn(3'd5, 4'd2, 5'd8, 0, 0, 0);
        run_txn(3'd4, 4'd3, 5'd21, 0, 0, 0);
        run_txn(3'd1, 4'd12, 5'd30, 30, 30, 0);
        run_txn(3'd6, 4'd5, 5'd2, 0, 20, 0);
        run_txn(3'd2, 4'd4, 5'd11, 20, 0, 0);

        // Reset while the third of eight Get response beats is presented.
        a_valid  = 1'b1;
        a_opcode = 3'd4;
        a_size   = 4'd6;
        a_source = 5'd9;
        @(posedge clock);
        @(negedge clock);
        a_valid = 1'b0;
        check_eq("mid_d_valid", 64'(d_valid), 64'(1));
        d_ready = 1'b1;
        repeat (2) begin
            @(posedge clock);
            @(negedge clock);
        end
        d_ready = 1'b0;
        check_eq("beat3_d_valid", 64'(d_valid), 64'(1));
        #2 reset = 1'b1;
        #1;
        check_eq("async_rst_d_valid", 64'(d_valid), 64'(0));
        check_eq("async_rst_a_ready", 64'(a_ready), 64'(0));
        repeat (2) @(negedge clock);
        check_eq("held_rst_d_valid", 64'(d_valid), 64'(0));
        reset = 1'b0;
        #1;
        check_eq("release_a_ready", 64'(a_ready), 64'(1));
        run_txn(3'd4, 4'd6, 5'd7, 0, 10, 0);

        for (int i = 0; i < 40; i++) begin
            run_txn(3'($urandom), 4'($urandom), 5'($urandom),
                    int'($urandom_range(40)), int'($urandom_range(50)),
                    int'($urandom_range(3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
